dmem_responder: RTL and testbench

Data-memory responder: the slave end of the pipeline's data-memory request interface. Accepts the address/write-data/write-enable/count request driven from EX, performs a byte-, half- or word-sized access on an internal word-organised RAM after a configurable latency, and returns read data plus a status code for the ME stage to sample. It sits outside the pipeline in the top-level alongside the instruction memory.

---
 rtl/dmem_responder_pkg.sv | 30 +++
 rtl/dmem_ram.sv | 37 +++
 rtl/dmem_responder.sv | 204 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder.
//   - Bus widths for the EX -> memory request and memory -> ME response.
//   - Response status codes (MEM_CODE_*) and request size encodings (MEM_COUNT_*).
//   - FSM state type used by dmem_responder.
package dmem_responder_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int MEM_CODE_W  = 3;
    localparam int MEM_COUNT_W = 2;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_IDLE     = 3'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_BUSY     = 3'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_RD_OK    = 3'd2;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_WR_OK    = 3'd3;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_FAULT    = 3'd4;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_MISALIGN = 3'd5;

    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_NONE = 2'd0;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_BYTE = 2'd1;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_HALF = 2'd2;
    localparam logic [MEM_COUNT_W-1:0] MEM_COUNT_WORD = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered
// (read-first) read port. No reset: contents survive a control reset.
//   clk   : rising-edge clock
//   en    : access strobe; read data register only updates when set
//   we    : byte-lane write enables, bit i covers wdata[8i+7:8i]
//   idx   : word index
//   wdata : write data, already replicated into the addressed lanes
//   rdata : word read on the last enabled edge (old contents on a write)
module dmem_ram #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [3:0]               we,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    // One byte-wide array per lane so each lane has a single writer.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [DEPTH];
        logic [7:0] q_lane_reg;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we[gi]) begin
                    mem_lane[idx] <= wdata[gi*8 +: 8];
                end
                q_lane_reg <= mem_lane[idx];
            end
        end

        assign rdata[gi*8 +: 8] = q_lane_reg;
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: slave end of the pipeline's data-memory request
// interface. Accepts a byte/half/word request, performs it on an internal
// word RAM LATENCY cycles later and presents read data plus a status code
// for one cycle.
//   clk, aresetn        : clock, asynchronous active-low reset (control only)
//   i_mem_req_addr      : byte address
//   i_mem_req_wr_data   : right-aligned write data
//   i_mem_req_wr_en     : 1 = write, 0 = read
//   i_mem_req_count     : 0 none, 1 byte, 2 half, 3 word
//   o_mem_res_rd_data   : right-aligned, zero-extended read data
//   o_mem_res_code      : response status (MEM_CODE_*)
// Build option: define DMEM_MISALIGN_CHECK_EN to reject misaligned half/word
// accesses with MEM_CODE_MISALIGN; otherwise low address bits are ignored.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [ADDR_W-1:0]      i_mem_req_addr,
    input  logic [WORD_W-1:0]      i_mem_req_wr_data,
    input  logic                   i_mem_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_mem_req_count,
    output logic [WORD_W-1:0]      o_mem_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_mem_res_code
);

    localparam int              IDX_W      = $clog2(DEPTH);
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(DEPTH) << 2;
    localparam logic [3:0]      LAT_M1     = 4'(LATENCY - 1);

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic [MEM_CODE_W-1:0]   code_reg, code_next;
    logic [1:0]              resp_lane_reg, resp_lane_next;
    logic [MEM_COUNT_W-1:0]  resp_count_reg, resp_count_next;
    logic                    resp_rd_ok_reg, resp_rd_ok_next;

    logic [ADDR_W-1:0]       addr_reg;
    logic [WORD_W-1:0]       wdata_reg;
    logic                    wr_en_reg;
    logic [MEM_COUNT_W-1:0]  count_reg;

    logic                    req_valid, accept, wait_done, enter_resp;
    logic [ADDR_W-1:0]       acc_addr;
    logic [WORD_W-1:0]       acc_wdata;
    logic                    acc_we;
    logic [MEM_COUNT_W-1:0]  acc_count;
    logic                    fault, misalign, access_ok;
    logic [1:0]              acc_lane;
    logic [3:0]              acc_be;
    logic [WORD_W-1:0]       acc_wlanes;
    logic [MEM_CODE_W-1:0]   result_code;
    logic                    ram_en;
    logic [3:0]              ram_we;
    logic [WORD_W-1:0]       ram_q, rd_shifted;

    assign req_valid  = (i_mem_req_count != MEM_COUNT_NONE);
    assign accept     = req_valid && (state_reg != ST_WAIT);
    assign wait_done  = (state_reg == ST_WAIT) && (cnt_reg == 4'd1);
    // The RAM is touched exactly once per request, on the edge that enters RESP.
    assign enter_resp = (accept && (LATENCY == 1)) || wait_done;

    // With LATENCY=1 the access happens on the accepting edge, so it must use
    // the live request; otherwise it uses the copy captured at acceptance.
    assign acc_addr  = (state_reg == ST_WAIT) ? addr_reg  : i_mem_req_addr;
    assign acc_wdata = (state_reg == ST_WAIT) ? wdata_reg : i_mem_req_wr_data;
    assign acc_we    = (state_reg == ST_WAIT) ? wr_en_reg : i_mem_req_wr_en;
    assign acc_count = (state_reg == ST_WAIT) ? count_reg : i_mem_req_count;

    assign fault = ({1'b0, acc_addr} >= ADDR_LIMIT);
`ifdef DMEM_MISALIGN_CHECK_EN
    assign misalign = ((acc_count == MEM_COUNT_HALF) && acc_addr[0]) ||
                      ((acc_count == MEM_COUNT_WORD) && (acc_addr[1:0] != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign access_ok = !fault && !misalign;

    // Lane steering: unused low address bits are dropped for half/word.
    always_comb begin
        acc_lane   = 2'd0;
        acc_be     = 4'b1111;
        acc_wlanes = acc_wdata;
        case (acc_count)
            MEM_COUNT_BYTE: begin
                acc_lane   = acc_addr[1:0];
                acc_be     = 4'b0001 << acc_addr[1:0];
                acc_wlanes = {4{acc_wdata[7:0]}};
            end
            MEM_COUNT_HALF: begin
                acc_lane   = {acc_addr[1], 1'b0};
                acc_be     = 4'b0011 << {acc_addr[1], 1'b0};
                acc_wlanes = {2{acc_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        if (fault)         result_code = MEM_CODE_FAULT;
        else if (misalign) result_code = MEM_CODE_MISALIGN;
        else if (acc_we)   result_code = MEM_CODE_WR_OK;
        else               result_code = MEM_CODE_RD_OK;
    end

    // Held in reset, no access may reach the RAM.
    assign ram_en = enter_resp && aresetn;
    assign ram_we = (ram_en && acc_we && access_ok) ? acc_be : 4'b0000;

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (acc_addr[IDX_W+1:2]),
        .wdata (acc_wlanes),
        .rdata (ram_q)
    );

    // Next-state / response logic.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        code_next       = MEM_CODE_IDLE;
        resp_lane_next  = 2'd0;
        resp_count_next = MEM_COUNT_NONE;
        resp_rd_ok_next = 1'b0;
        case (state_reg)
            ST_WAIT: begin
                if (!wait_done) begin
                    cnt_next  = cnt_reg - 4'd1;
                    code_next = MEM_CODE_BUSY;
                end
            end
            default: begin
                if (accept && !enter_resp) begin
                    state_next = ST_WAIT;
                    cnt_next   = LAT_M1;
                    code_next  = MEM_CODE_BUSY;
                end else if (!accept) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
        if (enter_resp) begin
            state_next      = ST_RESP;
            cnt_next        = 4'd0;
            code_next       = result_code;
            resp_lane_next  = acc_lane;
            resp_count_next = acc_count;
            resp_rd_ok_next = !acc_we && access_ok;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= 4'd0;
            code_reg       <= MEM_CODE_IDLE;
            resp_lane_reg  <= 2'd0;
            resp_count_reg <= MEM_COUNT_NONE;
            resp_rd_ok_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            code_reg       <= code_next;
            resp_lane_reg  <= resp_lane_next;
            resp_count_reg <= resp_count_next;
            resp_rd_ok_reg <= resp_rd_ok_next;
        end
    end

    // Request capture for multi-cycle latency; datapath only, no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_reg  <= i_mem_req_addr;
            wdata_reg <= i_mem_req_wr_data;
            wr_en_reg <= i_mem_req_wr_en;
            count_reg <= i_mem_req_count;
        end
    end

    // Read data is steered from the registered RAM output using registered
    // lane/size info, so it only depends on flops.
    assign rd_shifted = ram_q >> {resp_lane_reg, 3'b000};

    always_comb begin
        o_mem_res_rd_data = '0;
        if (resp_rd_ok_reg) begin
            case (resp_count_reg)
                MEM_COUNT_BYTE: o_mem_res_rd_data = {24'd0, rd_shifted[7:0]};
                MEM_COUNT_HALF: o_mem_res_rd_data = {16'd0, rd_shifted[15:0]};
                default:        o_mem_res_rd_data = rd_shifted;
            endcase
        end
    end

    assign o_mem_res_code = code_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder. Three instances share the request
// bus (LATENCY 1, 4 and 3); each has its own reset so only the instance under
// test is active. The LATENCY=1 instance is checked against a byte-addressed
// memory model under directed and random traffic.
module tb_dmem_responder;

    localparam int TB_DEPTH = 64;
    localparam int LIMIT    = TB_DEPTH * 4;

    logic        clk = 1'b0;
    logic        rstn1, rstn4, rstn3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [1:0]  req_cnt;
    logic [31:0] rd1, rd4, rd3;
    logic [2:0]  code1, code4, code3;

    int vectors = 0;
    int errors  = 0;

    logic [7:0] model_mem [LIMIT];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(TB_DEPTH), .LATENCY(1)) u_dut1 (
        .clk(clk), .aresetn(rstn1),
        .i_mem_req_addr(req_addr), .i_mem_req_wr_data(req_wdata),
        .i_mem_req_wr_en(req_we), .i_mem_req_count(req_cnt),
        .o_mem_res_rd_data(rd1), .o_mem_res_code(code1)
    );

    dmem_responder #(.DEPTH(TB_DEPTH), .LATENCY(4)) u_dut4 (
        .clk(clk), .aresetn(rstn4),
        .i_mem_req_addr(req_addr), .i_mem_req_wr_data(req_wdata),
        .i_mem_req_wr_en(req_we), .i_mem_req_count(req_cnt),
        .o_mem_res_rd_data(rd4), .o_mem_res_code(code4)
    );

    dmem_responder #(.DEPTH(TB_DEPTH), .LATENCY(3)) u_dut3 (
        .clk(clk), .aresetn(rstn3),
        .i_mem_req_addr(req_addr), .i_mem_req_wr_data(req_wdata),
        .i_mem_req_wr_en(req_we), .i_mem_req_count(req_cnt),
        .o_mem_res_rd_data(rd3), .o_mem_res_code(code3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] wd,
                         input logic we, input logic [1:0] cnt);
        req_addr  = a;
        req_wdata = wd;
        req_we    = we;
        req_cnt   = cnt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: byte-addressed memory, sizes in bytes.
    task automatic model_req(input logic [31:0] a, input logic [31:0] wd,
                             input logic we, input logic [1:0] cnt,
                             output logic [31:0] code, output logic [31:0] data);
        int nbytes;
        int base;
        code = 32'd0;
        data = 32'd0;
        if (cnt == 2'd0) return;
        if (a >= LIMIT) begin
            code = 32'd4;
            return;
        end
        nbytes = (cnt == 2'd1) ? 1 : (cnt == 2'd2) ? 2 : 4;
`ifdef DMEM_MISALIGN_CHECK_EN
        if ((a % nbytes) != 0) begin
            code = 32'd5;
            return;
        end
`endif
        base = int'(a) - (int'(a) % nbytes);
        if (we) begin
            for (int i = 0; i < nbytes; i++) model_mem[base + i] = wd[8*i +: 8];
            code = 32'd3;
        end else begin
            for (int i = 0; i < nbytes; i++) data = data | (32'(model_mem[base + i]) << (8 * i));
            code = 32'd2;
        end
    endtask

    // One LATENCY=1 transaction: response is visible right after the next edge.
    task automatic l1_txn(input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic [1:0] cnt);
        logic [31:0] ec, ed;
        model_req(a, wd, we, cnt, ec, ed);
        drive(a, wd, we, cnt);
        step();
        $display("txn L1 addr=%08h wd=%08h we=%0d cnt=%0d -> code=%0d data=%08h (exp %0d/%08h)",
                 a, wd, we, cnt, code1, rd1, ec, ed);
        chk("l1_code", {29'd0, code1}, ec);
        chk("l1_data", rd1, ed);
    endtask

    initial begin
        rstn1 = 1'b0;
        rstn4 = 1'b0;
        rstn3 = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 2'd0);
        step();
        step();
        chk("rst_code1", {29'd0, code1}, 32'd0);
        chk("rst_data1", rd1, 32'd0);
        chk("rst_code4", {29'd0, code4}, 32'd0);
        chk("rst_data4", rd4, 32'd0);
        chk("rst_code3", {29'd0, code3}, 32'd0);
        chk("rst_data3", rd3, 32'd0);

        // ---------------- LATENCY=1 instance ----------------
        rstn1 = 1'b1;
        step();
        for (int w = 0; w < TB_DEPTH; w++) l1_txn(32'(w * 4), $urandom, 1'b1, 2'd3);

        l1_txn(32'h10, 32'hDEADBEEF, 1'b1, 2'd3);
        chk("tp_wr_code", {29'd0, code1}, 32'd3);
        l1_txn(32'h10, 32'h0, 1'b0, 2'd3);
        chk("tp_rd_word", rd1, 32'hDEADBEEF);
        l1_txn(32'h13, 32'h000000AA, 1'b1, 2'd1);
        l1_txn(32'h10, 32'h0, 1'b0, 2'd3);
        chk("tp_rd_merged", rd1, 32'hAAADBEEF);
        l1_txn(32'h13, 32'h0, 1'b0, 2'd1);
        chk("tp_rd_byte", rd1, 32'h000000AA);
        l1_txn(32'h12, 32'h0, 1'b0, 2'd2);
        chk("tp_rd_half", rd1, 32'h0000AAAD);

        l1_txn(32'(LIMIT), 32'h11111111, 1'b1, 2'd3);
        chk("tp_fault_code", {29'd0, code1}, 32'd4);
        l1_txn(32'h0, 32'h0, 1'b0, 2'd3);

        l1_txn(32'h11, 32'h55667788, 1'b1, 2'd3);
        l1_txn(32'h10, 32'h0, 1'b0, 2'd3);
        l1_txn(32'h0, 32'h0, 1'b0, 2'd0);

        for (int n = 0; n < 400; n++) begin
            l1_txn(32'($urandom_range(0, LIMIT + 15)), $urandom,
                   1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
        end
        l1_txn(32'h0, 32'h0, 1'b0, 2'd0);

        // ---------------- LATENCY=4 instance ----------------
        rstn1 = 1'b0;
        rstn4 = 1'b1;
        step();
        drive(32'h20, 32'h12345678, 1'b1, 2'd3);
        step();
        chk("l4_wr_busy1", {29'd0, code4}, 32'd1);
        drive(32'h0, 32'h0, 1'b0, 2'd0);
        step();
        chk("l4_wr_busy2", {29'd0, code4}, 32'd1);
        step();
        chk("l4_wr_busy3", {29'd0, code4}, 32'd1);
        step();
        $display("txn L4 write addr=00000020 -> code=%0d data=%08h", code4, rd4);
        chk("l4_wr_ok", {29'd0, code4}, 32'd3);
        chk("l4_wr_data", rd4, 32'd0);
        step();
        chk("l4_idle", {29'd0, code4}, 32'd0);

        drive(32'h20, 32'h0, 1'b0, 2'd3);
        step();
        chk("l4_rd_busy1", {29'd0, code4}, 32'd1);
        drive(32'h20, 32'hFFFFFFFF, 1'b1, 2'd3);
        step();
        chk("l4_rd_busy2", {29'd0, code4}, 32'd1);
        step();
        chk("l4_rd_busy3", {29'd0, code4}, 32'd1);
        drive(32'h0, 32'h0, 1'b0, 2'd0);
        step();
        $display("txn L4 read addr=00000020 -> code=%0d data=%08h", code4, rd4);
        chk("l4_rd_ok", {29'd0, code4}, 32'd2);
        chk("l4_rd_data", rd4, 32'h12345678);
        step();
        chk("l4_rd_idle", {29'd0, code4}, 32'd0);
        drive(32'h20, 32'h0, 1'b0, 2'd3);
        step();
        drive(32'h0, 32'h0, 1'b0, 2'd0);
        step();
        step();
        step();
        $display("txn L4 reread addr=00000020 -> code=%0d data=%08h", code4, rd4);
        chk("l4_ignored_wr", rd4, 32'h12345678);

        // ---------------- LATENCY=3 instance ----------------
        rstn4 = 1'b0;
        rstn3 = 1'b1;
        step();
        drive(32'h40, 32'hCAFEF00D, 1'b1, 2'd3);
        step();
        drive(32'h0, 32'h0, 1'b0, 2'd0);
        step();
        step();
        $display("txn L3 write addr=00000040 -> code=%0d data=%08h", code3, rd3);
        chk("l3_wr_ok", {29'd0, code3}, 32'd3);
        step();
        drive(32'h40, 32'h0BADBEEF, 1'b1, 2'd3);
        step();
        chk("l3_busy", {29'd0, code3}, 32'd1);
        drive(32'h0, 32'h0, 1'b0, 2'd0);
        #1 rstn3 = 1'b0;
        #1;
        chk("l3_rst_code", {29'd0, code3}, 32'd0);
        chk("l3_rst_data", rd3, 32'd0);
        step();
        rstn3 = 1'b1;
        step();
        drive(32'h40, 32'h0, 1'b0, 2'd3);
        step();
        drive(32'h0, 32'h0, 1'b0, 2'd0);
        step();
        step();
        $display("txn L3 read addr=00000040 -> code=%0d data=%08h", code3, rd3);
        chk("l3_rd_ok", {29'd0, code3}, 32'd2);
        chk("l3_rd_old", rd3, 32'hCAFEF00D);
        #1 rstn3 = 1'b0;
        #1;
        chk("l3_rst_resp_code", {29'd0, code3}, 32'd0);
        chk("l3_rst_resp_data", rd3, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
